decode_cmd_queue: RTL and testbench

//  Parametrised, registered command queue between the command decoder and the

---
 rtl/decode_cmd_queue.sv | 210 +++++++++++++++++++++
 tb/tb_decode_cmd_queue.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_cmd_queue.sv
// decode_cmd_queue
//   Registered circular command queue between the instruction decoder and the
//   micro stage. Holds decoded commands so decode can run ahead while micro
//   stalls. The next-instruction eip is computed once, at enqueue. Once an
//   entry carrying #UD has been accepted, the queue stops accepting until the
//   pipeline is flushed (dec_reset) or reset.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   dec_reset         pipeline flush: empties the queue and leaves UD_LOCK
//   in_valid/in_ready decoder handshake; in_* carry the decoded command
//   out_valid/out_ready micro handshake; out_* present the head entry
//   out_eip_next      head eip + head length (mod 2^EIP_W)
//   count             number of occupied entries
//   ud_locked         queue is refusing input after a #UD entry
module decode_cmd_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CMD_W   = 7,
    parameter int unsigned CMDEX_W = 4,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned EIP_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dec_reset,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CMD_W-1:0]             in_cmd,
    input  logic [CMDEX_W-1:0]           in_cmdex,
    input  logic                         in_is_8bit,
    input  logic                         in_is_complex,
    input  logic                         in_exception_ud,
    input  logic [LEN_W-1:0]             in_consumed,
    input  logic [EIP_W-1:0]             in_eip,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CMD_W-1:0]             out_cmd,
    output logic [CMDEX_W-1:0]           out_cmdex,
    output logic                         out_is_8bit,
    output logic                         out_is_complex,
    output logic                         out_exception_ud,
    output logic [LEN_W-1:0]             out_consumed,
    output logic [EIP_W-1:0]             out_eip,
    output logic [EIP_W-1:0]             out_eip_next,

    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ud_locked
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CMD_W-1:0]   cmd;
        logic [CMDEX_W-1:0] cmdex;
        logic               is_8bit;
        logic               is_complex;
        logic               exception_ud;
        logic [LEN_W-1:0]   consumed;
        logic [EIP_W-1:0]   eip;
        logic [EIP_W-1:0]   eip_next;
    } entry_t;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_UD_LOCK = 1'b1
    } state_t;

    // Storage (not reset) and control registers
    entry_t               mem_q [DEPTH];

    state_t               state_q,     state_d;
    logic [PTR_W-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]     count_q,     count_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ud_locked_q, ud_locked_d;
    entry_t               head_q,      head_d;

    logic                 enq_c;
    logic                 deq_c;
    entry_t               wr_entry_c;

    // Accept only when not full and not locked; depends on registers only
    assign in_ready = (count_q != CNT_W'(DEPTH)) && (state_q == ST_RUN);
    assign enq_c    = in_valid && in_ready;
    assign deq_c    = out_valid_q && out_ready;

    // Entry as it will be stored, with the follow-on eip precomputed
    always_comb begin
        wr_entry_c              = '0;
        wr_entry_c.cmd          = in_cmd;
        wr_entry_c.cmdex        = in_cmdex;
        wr_entry_c.is_8bit      = in_is_8bit;
        wr_entry_c.is_complex   = in_is_complex;
        wr_entry_c.exception_ud = in_exception_ud;
        wr_entry_c.consumed     = in_consumed;
        wr_entry_c.eip          = in_eip;
        wr_entry_c.eip_next     = in_eip + EIP_W'(in_consumed);
    end

    // Next-state: pointers, occupancy, lock state and registered head copy
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        head_d      = head_q;
        out_valid_d = out_valid_q;
        ud_locked_d = ud_locked_q;

        if (dec_reset) begin
            // Flush wins over any handshake in the same cycle
            state_d  = ST_RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({enq_c, deq_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            unique case (state_q)
                ST_RUN: begin
                    if (enq_c && in_exception_ud) begin
                        state_d = ST_UD_LOCK;
                    end
                end
                ST_UD_LOCK: begin
                    state_d = ST_UD_LOCK;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            // Head for next cycle; the entry being written bypasses storage
            // when it lands exactly at the new read pointer.
            if (count_d != '0) begin
                if (enq_c && (rd_ptr_d == wr_ptr_q)) begin
                    head_d = wr_entry_c;
                end else begin
                    head_d = mem_q[rd_ptr_d];
                end
            end
        end

        out_valid_d = (count_d != '0);
        ud_locked_d = (state_d == ST_UD_LOCK);
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            ud_locked_q <= 1'b0;
            head_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            ud_locked_q <= ud_locked_d;
            head_q      <= head_d;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (rst_n && !dec_reset && enq_c) begin
            mem_q[wr_ptr_q] <= wr_entry_c;
        end
    end

    // Overflow / underflow cannot happen by construction
    always_ff @(posedge clk) begin
        if (rst_n && !dec_reset) begin
            assert (!(enq_c && (count_q == CNT_W'(DEPTH))));
            assert (!(deq_c && (count_q == '0)));
        end
    end

    assign out_cmd          = head_q.cmd;
    assign out_cmdex        = head_q.cmdex;
    assign out_is_8bit      = head_q.is_8bit;
    assign out_is_complex   = head_q.is_complex;
    assign out_exception_ud = head_q.exception_ud;
    assign out_consumed     = head_q.consumed;
    assign out_eip          = head_q.eip;
    assign out_eip_next     = head_q.eip_next;
    assign out_valid        = out_valid_q;
    assign count            = count_q;
    assign ud_locked        = ud_locked_q;

endmodule

// File: tb/tb_decode_cmd_queue.sv
module tb_decode_cmd_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CMD_W   = 7;
    localparam int unsigned CMDEX_W = 4;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned EIP_W   = 32;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic               clk;
    logic               rst_n;
    logic               dec_reset;
    logic               in_valid;
    logic               in_ready;
    logic [CMD_W-1:0]   in_cmd;
    logic [CMDEX_W-1:0] in_cmdex;
    logic               in_is_8bit;
    logic               in_is_complex;
    logic               in_exception_ud;
    logic [LEN_W-1:0]   in_consumed;
    logic [EIP_W-1:0]   in_eip;
    logic               out_valid;
    logic               out_ready;
    logic [CMD_W-1:0]   out_cmd;
    logic [CMDEX_W-1:0] out_cmdex;
    logic               out_is_8bit;
    logic               out_is_complex;
    logic               out_exception_ud;
    logic [LEN_W-1:0]   out_consumed;
    logic [EIP_W-1:0]   out_eip;
    logic [EIP_W-1:0]   out_eip_next;
    logic [CNT_W-1:0]   count;
    logic               ud_locked;

    int n_checks = 0;
    int n_errors = 0;

    decode_cmd_queue #(
        .DEPTH(DEPTH), .CMD_W(CMD_W), .CMDEX_W(CMDEX_W), .LEN_W(LEN_W), .EIP_W(EIP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dec_reset(dec_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_cmdex(in_cmdex),
        .in_is_8bit(in_is_8bit), .in_is_complex(in_is_complex),
        .in_exception_ud(in_exception_ud), .in_consumed(in_consumed), .in_eip(in_eip),
        .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
        .out_cmdex(out_cmdex), .out_is_8bit(out_is_8bit), .out_is_complex(out_is_complex),
        .out_exception_ud(out_exception_ud), .out_consumed(out_consumed),
        .out_eip(out_eip), .out_eip_next(out_eip_next), .count(count), .ud_locked(ud_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model entry for the randomized phase
    typedef struct {
        logic [CMD_W-1:0]   cmd;
        logic [CMDEX_W-1:0] cmdex;
        logic               b8;
        logic               cx;
        logic               ud;
        logic [LEN_W-1:0]   len;
        logic [EIP_W-1:0]   eip;
    } mentry_t;

    // Table vectors: one enqueue, then the head is checked
    typedef struct {
        logic [EIP_W-1:0]   eip;
        logic [LEN_W-1:0]   len;
        logic [CMD_W-1:0]   cmd;
        logic [CMDEX_W-1:0] cmdex;
        logic               b8;
        logic               cx;
        logic [EIP_W-1:0]   exp_next;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        dec_reset       = 1'b0;
        in_cmd          = '0;
        in_cmdex        = '0;
        in_is_8bit      = 1'b0;
        in_is_complex   = 1'b0;
        in_exception_ud = 1'b0;
        in_consumed     = 4'd1;
        in_eip          = '0;
    endtask

    task automatic drive(input logic [CMD_W-1:0] c, input logic ud);
        in_valid        = 1'b1;
        in_cmd          = c;
        in_exception_ud = ud;
    endtask

    mentry_t model_q[$];
    vec_t    vecs[6];

    initial begin
        logic    m_locked;
        logic    m_in_ready;
        mentry_t e;
        mentry_t h;
        logic [EIP_W-1:0] exp_next;

        idle();
        rst_n = 1'b0;

        // Reset
        step();
        step();
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_ud_locked", 64'(ud_locked), 64'd0);
        chk("rst_out_cmd", 64'(out_cmd), 64'd0);
        chk("rst_out_eip_next", 64'(out_eip_next), 64'd0);

        // Fill with out_ready low, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(CMD_W'(i), 1'b0);
            step();
        end
        in_valid = 1'b0;
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_head", 64'(out_cmd), 64'd1);
        // Full: a same-cycle dequeue must not open the input
        drive(CMD_W'(99), 1'b0);
        out_ready = 1'b1;
        chk("full_deq_in_ready", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;
        chk("full_deq_count", 64'(count), 64'd3);
        for (int i = 2; i <= 4; i++) begin
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("drain_cmd", 64'(out_cmd), 64'(i));
            chk("drain_count", 64'(count), 64'(5 - i));
            step();
        end
        chk("drain_empty_count", 64'(count), 64'd0);
        chk("drain_empty_valid", 64'(out_valid), 64'd0);

        // Steady count=2 with simultaneous enq+deq across pointer wrap
        out_ready = 1'b0;
        drive(CMD_W'(10), 1'b0); step();
        drive(CMD_W'(11), 1'b0); step();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(CMD_W'(12 + k), 1'b0);
            chk("wrap_count", 64'(count), 64'd2);
            chk("wrap_cmd", 64'(out_cmd), 64'(10 + k));
            step();
        end
        in_valid = 1'b0;
        chk("wrap_end_count", 64'(count), 64'd2);
        chk("wrap_end_cmd", 64'(out_cmd), 64'd20);
        step();
        chk("wrap_last_cmd", 64'(out_cmd), 64'd21);
        step();
        chk("wrap_drained", 64'(count), 64'd0);

        // eip table
        vecs[0] = '{32'hFFFF_FFFE, 4'd3,  7'd40, 4'h1, 1'b1, 1'b0, 32'h0000_0001};
        vecs[1] = '{32'h0000_1000, 4'd15, 7'd41, 4'h2, 1'b0, 1'b1, 32'h0000_100F};
        vecs[2] = '{32'hFFFF_FFFF, 4'd1,  7'd42, 4'hF, 1'b1, 1'b1, 32'h0000_0000};
        vecs[3] = '{32'h0000_0000, 4'd1,  7'd43, 4'h0, 1'b0, 1'b0, 32'h0000_0001};
        vecs[4] = '{32'h7FFF_FFF0, 4'd15, 7'd44, 4'h7, 1'b0, 1'b1, 32'h7FFF_FFFF};
        vecs[5] = '{32'hFFFF_FFF8, 4'd8,  7'h7F, 4'hA, 1'b1, 1'b0, 32'h0000_0000};
        for (int v = 0; v < 6; v++) begin
            out_ready     = 1'b0;
            drive(vecs[v].cmd, 1'b0);
            in_eip        = vecs[v].eip;
            in_consumed   = vecs[v].len;
            in_cmdex      = vecs[v].cmdex;
            in_is_8bit    = vecs[v].b8;
            in_is_complex = vecs[v].cx;
            step();
            idle();
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk("vec_cmd", 64'(out_cmd), 64'(vecs[v].cmd));
            chk("vec_cmdex", 64'(out_cmdex), 64'(vecs[v].cmdex));
            chk("vec_8bit", 64'(out_is_8bit), 64'(vecs[v].b8));
            chk("vec_complex", 64'(out_is_complex), 64'(vecs[v].cx));
            chk("vec_len", 64'(out_consumed), 64'(vecs[v].len));
            chk("vec_eip", 64'(out_eip), 64'(vecs[v].eip));
            chk("vec_eip_next", 64'(out_eip_next), 64'(vecs[v].exp_next));
            out_ready = 1'b1;
            step();
            chk("vec_drained", 64'(count), 64'd0);
        end
        idle();

        // #UD lock
        drive(CMD_W'(5), 1'b1);
        step();
        idle();
        chk("ud_locked", 64'(ud_locked), 64'd1);
        chk("ud_in_ready", 64'(in_ready), 64'd0);
        chk("ud_count", 64'(count), 64'd1);
        drive(CMD_W'(6), 1'b0);
        out_ready = 1'b1;
        chk("ud_head_cmd", 64'(out_cmd), 64'd5);
        chk("ud_head_flag", 64'(out_exception_ud), 64'd1);
        step();
        idle();
        chk("ud_drain_count", 64'(count), 64'd0);
        chk("ud_still_locked", 64'(ud_locked), 64'd1);
        chk("ud_still_blocked", 64'(in_ready), 64'd0);
        dec_reset = 1'b1;
        step();
        dec_reset = 1'b0;
        chk("ud_release_lock", 64'(ud_locked), 64'd0);
        chk("ud_release_ready", 64'(in_ready), 64'd1);

        // Flush overrides simultaneous enq and deq
        for (int i = 0; i < 3; i++) begin
            drive(CMD_W'(30 + i), 1'b0);
            step();
        end
        chk("flush_pre_count", 64'(count), 64'd3);
        drive(CMD_W'(33), 1'b0);
        out_ready = 1'b1;
        dec_reset = 1'b1;
        step();
        idle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        drive(CMD_W'(34), 1'b0);
        step();
        idle();
        chk("flush_next_cmd", 64'(out_cmd), 64'd34);
        chk("flush_next_count", 64'(count), 64'd1);

        // Reset beats flush and in-flight enqueue
        drive(CMD_W'(35), 1'b1);
        dec_reset = 1'b1;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_cmd", 64'(out_cmd), 64'd0);
        chk("midrst_lock", 64'(ud_locked), 64'd0);

        // Randomized run against a queue model
        m_locked = 1'b0;
        model_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid        = ($urandom_range(0, 9) < 7);
            out_ready       = ($urandom_range(0, 9) < 6);
            dec_reset       = ($urandom_range(0, 31) == 0);
            in_cmd          = CMD_W'($urandom);
            in_cmdex        = CMDEX_W'($urandom);
            in_is_8bit      = 1'($urandom);
            in_is_complex   = 1'($urandom);
            in_exception_ud = ($urandom_range(0, 15) == 0);
            in_consumed     = LEN_W'($urandom_range(1, 15));
            in_eip          = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | EIP_W'($urandom_range(0, 15)))
                                                           : EIP_W'($urandom);

            m_in_ready = (model_q.size() < DEPTH) && !m_locked;
            chk("rnd_in_ready", 64'(in_ready), 64'(m_in_ready));
            chk("rnd_count", 64'(count), 64'(model_q.size()));
            chk("rnd_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            chk("rnd_ud_locked", 64'(ud_locked), 64'(m_locked));
            if (model_q.size() != 0) begin
                h = model_q[0];
                exp_next = h.eip + {{(EIP_W-LEN_W){1'b0}}, h.len};
                chk("rnd_head", {out_cmd, out_cmdex, out_is_8bit, out_is_complex, out_exception_ud, out_consumed},
                    {h.cmd, h.cmdex, h.b8, h.cx, h.ud, h.len});
                chk("rnd_eip", 64'(out_eip), 64'(h.eip));
                chk("rnd_eip_next", 64'(out_eip_next), 64'(exp_next));
            end

            if (dec_reset) begin
                model_q.delete();
                m_locked = 1'b0;
            end else begin
                if (out_ready && model_q.size() != 0) begin
                    void'(model_q.pop_front());
                end
                if (in_valid && m_in_ready) begin
                    e.cmd = in_cmd; e.cmdex = in_cmdex; e.b8 = in_is_8bit; e.cx = in_is_complex;
                    e.ud = in_exception_ud; e.len = in_consumed; e.eip = in_eip;
                    model_q.push_back(e);
                    if (in_exception_ud) m_locked = 1'b1;
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
